// File: rtl/fuzzy_arbiter.sv
// Round-robin arbiter that shares one fuzzy-logic coprocessor among NREQ requesters.
// Each grant runs a START/WAIT/RESP exchange with a timeout and returns a per-requester result pulse.
module fuzzy_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_T,
  input  logic [8*NREQ-1:0] req_dT,
  input  logic [NREQ-1:0]   req_reg_mode,
  input  logic [NREQ-1:0]   req_dt_mode,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_G,
  output logic              rsp_err,
  output logic              busy,
  output logic              cp_start,
  output logic [7:0]        cp_T,
  output logic [7:0]        cp_dT,
  output logic              cp_reg_mode,
  output logic              cp_dt_mode,
  input  logic              cp_valid,
  input  logic [7:0]        cp_G,
  output logic [1:0]        dbg_state
);

  localparam int IW = $clog2(NREQ);

  // Handshake: req is a level held by the requester until its rsp_valid bit; it is
  // sampled only in IDLE. cp_start is a one-cycle command; cp_valid is honoured only
  // in WAIT, so stray or late DONE pulses are dropped.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [NREQ-1:0] r_rsp_valid, w_rsp_valid;
  logic [7:0]      r_rsp_G, w_rsp_G;
  logic            r_rsp_err, w_rsp_err;
  logic            r_busy, w_busy;
  logic            r_cp_start, w_cp_start;
  logic [7:0]      r_cp_T, w_cp_T;
  logic [7:0]      r_cp_dT, w_cp_dT;
  logic            r_cp_reg_mode, w_cp_reg_mode;
  logic            r_cp_dt_mode, w_cp_dt_mode;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr;
  logic [IW-1:0]   r_owner, w_owner;
  logic [7:0]      r_cnt, w_cnt;

  logic [7:0]      w_op_T  [NREQ];
  logic [7:0]      w_op_dT [NREQ];
  logic            w_sel_found;
  logic [IW-1:0]   w_sel_idx;
  int              w_scan;
  logic [8:0]      w_cnt_inc;
  logic            w_timeout;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_T[gi]  = req_T[8*gi +: 8];
    assign w_op_dT[gi] = req_dT[8*gi +: 8];
  end

  // Circular priority scan: first requesting index at or after r_rr_ptr.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      if (!w_sel_found && req[w_scan[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_scan[IW-1:0];
      end
    end
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_timeout = (w_cnt_inc == 9'(TIMEOUT));

  always_comb begin
    w_state       = r_state;
    w_gnt         = r_gnt;
    w_rsp_valid   = '0;
    w_rsp_G       = r_rsp_G;
    w_rsp_err     = r_rsp_err;
    w_cp_start    = 1'b0;
    w_cp_T        = r_cp_T;
    w_cp_dT       = r_cp_dT;
    w_cp_reg_mode = r_cp_reg_mode;
    w_cp_dt_mode  = r_cp_dt_mode;
    w_rr_ptr      = r_rr_ptr;
    w_owner       = r_owner;
    w_cnt         = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state       = ST_START;
          w_owner       = w_sel_idx;
          w_gnt         = NREQ'(1) << w_sel_idx;
          w_cp_T        = w_op_T[w_sel_idx];
          w_cp_dT       = w_op_dT[w_sel_idx];
          w_cp_reg_mode = req_reg_mode[w_sel_idx];
          w_cp_dt_mode  = req_dt_mode[w_sel_idx];
          w_cp_start    = 1'b1;
        end
      end
      ST_START: begin
        w_cnt   = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt = w_cnt_inc[7:0];
        // A DONE arriving on the timeout cycle still counts as success.
        if (cp_valid) begin
          w_rsp_G   = cp_G;
          w_rsp_err = 1'b0;
          w_state   = ST_RESP;
        end else if (w_timeout) begin
          w_rsp_G   = 8'd0;
          w_rsp_err = 1'b1;
          w_state   = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = r_gnt;
        w_gnt       = '0;
        w_rr_ptr    = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
        w_state     = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_G       <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_cp_start    <= 1'b0;
      r_cp_T        <= '0;
      r_cp_dT       <= '0;
      r_cp_reg_mode <= 1'b0;
      r_cp_dt_mode  <= 1'b0;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state;
      r_gnt         <= w_gnt;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_G       <= w_rsp_G;
      r_rsp_err     <= w_rsp_err;
      r_busy        <= w_busy;
      r_cp_start    <= w_cp_start;
      r_cp_T        <= w_cp_T;
      r_cp_dT       <= w_cp_dT;
      r_cp_reg_mode <= w_cp_reg_mode;
      r_cp_dt_mode  <= w_cp_dt_mode;
      r_rr_ptr      <= w_rr_ptr;
      r_owner       <= w_owner;
      r_cnt         <= w_cnt;
    end
  end

  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_G       = r_rsp_G;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;
  assign cp_start    = r_cp_start;
  assign cp_T        = r_cp_T;
  assign cp_dT       = r_cp_dT;
  assign cp_reg_mode = r_cp_reg_mode;
  assign cp_dt_mode  = r_cp_dt_mode;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fuzzy_arbiter.sv
// Bench for fuzzy_arbiter: directed scenarios plus randomized traffic, checked
// against a round-robin / latency / timeout reference model.
module tb_fuzzy_arbiter;

  localparam int N  = 4;
  localparam int TO = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_T, req_dT;
  logic [N-1:0]  req_reg_mode, req_dt_mode;
  logic [N-1:0]  gnt, rsp_valid;
  logic [7:0]    rsp_G;
  logic          rsp_err, busy, cp_start;
  logic [7:0]    cp_T, cp_dT;
  logic          cp_reg_mode, cp_dt_mode;
  logic          cp_valid;
  logic [7:0]    cp_G;
  logic [1:0]    dbg_state;

  logic [7:0]    t_in  [N];
  logic [7:0]    dt_in [N];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            ref_ptr = 0;
  logic [N-1:0]  last_gnt;

  always_comb begin
    req_T  = '0;
    req_dT = '0;
    for (int i = 0; i < N; i++) begin
      req_T[8*i +: 8]  = t_in[i];
      req_dT[8*i +: 8] = dt_in[i];
    end
  end

  fuzzy_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_T(req_T), .req_dT(req_dT),
    .req_reg_mode(req_reg_mode), .req_dt_mode(req_dt_mode),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_G(rsp_G), .rsp_err(rsp_err),
    .busy(busy), .cp_start(cp_start), .cp_T(cp_T), .cp_dT(cp_dT),
    .cp_reg_mode(cp_reg_mode), .cp_dt_mode(cp_dt_mode),
    .cp_valid(cp_valid), .cp_G(cp_G), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, gnt, rsp_valid, rsp_G, rsp_err, busy, cp_start,
            cp_T, cp_dT, cp_reg_mode, cp_dt_mode, dbg_state};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", all_outs(), 64'd0);
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  // Called at a negedge with the DUT able to grant at the next rising edge.
  // delay = WAIT cycle on which the coprocessor answers (0 = never).
  task automatic run_txn(input int delay, input logic [7:0] g_val, input int mutate_at);
    int own = -1;
    int cyc = 0;
    int exp_w;
    logic seen = 1'b0;
    logic ok_cp, exp_err;
    logic [1:0] own_i;
    logic [7:0] exp_g;
    logic [17:0] exp_ops;
    for (int k = 0; k < N; k++)
      if (own < 0 && req[(ref_ptr + k) % N]) own = (ref_ptr + k) % N;
    own_i   = 2'(own);
    ok_cp   = (delay >= 1 && delay <= TO);
    exp_w   = ok_cp ? delay : TO;
    exp_err = !ok_cp;
    exp_g   = ok_cp ? g_val : 8'd0;
    exp_ops = {t_in[own], dt_in[own], req_reg_mode[own_i], req_dt_mode[own_i]};
    @(negedge clk);
    chk("gnt", gnt, 64'(N'(1) << own));
    chk("cp_start_hi", cp_start, 1);
    chk("state_start", dbg_state, 2'd1);
    chk("cp_ops_grant", {cp_T, cp_dT, cp_reg_mode, cp_dt_mode}, exp_ops);
    chk("prev_rsp_cleared", rsp_valid, 0);
    while (!seen && cyc < 300) begin
      cp_valid = (delay > 0 && cyc == delay);
      cp_G     = cp_valid ? g_val : 8'($urandom_range(0, 255));
      if (cyc == mutate_at) begin
        t_in[own] = 8'd90;
        req[own_i] = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("cp_start_lo", cp_start, 0);
      if (mutate_at >= 0 && cyc == mutate_at + 2) chk("cp_T_hold", cp_T, exp_ops[17:10]);
      if (rsp_valid != '0) seen = 1'b1;
    end
    cp_valid = 1'b0;
    chk("rsp_seen", seen, 1);
    chk("latency", cyc + 1, exp_w + 3);
    chk("rsp_valid", rsp_valid, 64'(N'(1) << own));
    chk("rsp_G", rsp_G, exp_g);
    chk("rsp_err", rsp_err, exp_err);
    chk("gnt_cleared", gnt, 0);
    chk("cp_ops_hold", {cp_T, cp_dT, cp_reg_mode, cp_dt_mode}, exp_ops);
    ref_ptr  = (own + 1) % N;
    last_gnt = N'(1) << own;
  endtask

  task automatic watch_quiet(input int n, input int late_at, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      cp_valid = (i == late_at);
      cp_G     = 8'd55;
      @(negedge clk);
      if (rsp_valid != '0 || busy || gnt != '0) bad++;
    end
    cp_valid = 1'b0;
    chk(tag, bad, 0);
  endtask

  initial begin
    logic [N-1:0] pending;
    rst = 1'b1; req = '0; req_reg_mode = '0; req_dt_mode = '0;
    cp_valid = 1'b0; cp_G = '0;
    for (int i = 0; i < N; i++) begin t_in[i] = '0; dt_in[i] = '0; end
    do_reset();

    // Single request with known operands and result.
    t_in[0] = 8'd20; dt_in[0] = 8'hFB; req_reg_mode = 4'b0001; req_dt_mode = 4'b0000;
    req = 4'b0001;
    run_txn(9, 8'd73, -1);
    req = '0;
    watch_quiet(2, -1, "idle_after_single");

    // Round-robin with all requesters held.
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      run_txn($urandom_range(1, 12), 8'($urandom_range(0, 100)), -1);
      chk("rr_order", last_gnt, 64'(N'(1) << (r % N)));
    end
    req = '0;

    // Timeout, then a late DONE that must be ignored.
    req = 4'b0010;
    run_txn(0, 8'd99, -1);
    req = '0;
    watch_quiet(12, 4, "late_valid_ignored");
    chk("rsp_G_held", rsp_G, 0);
    chk("rsp_err_held", rsp_err, 1);

    // DONE on the timeout cycle wins; one cycle later it is too late.
    req = 4'b0001;
    run_txn(TO, 8'h5A, -1);
    run_txn(TO + 1, 8'h33, -1);
    req = '0;

    // Operand change and req drop after grant.
    t_in[2] = 8'd10; dt_in[2] = 8'd3;
    req = 4'b0100;
    run_txn(9, 8'd61, 4);
    chk("req_dropped", req, 0);
    watch_quiet(2, -1, "idle_after_drop");

    // Reset during WAIT abandons the transaction.
    t_in[0] = 8'd33;
    req = 4'b0001;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("state_wait", dbg_state, 2'd2);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("rst_mid_wait", all_outs(), 64'd0);
    rst = 1'b0; ref_ptr = 0;
    watch_quiet(8, 1, "no_rsp_after_rst");
    t_in[2] = 8'd77;
    req = 4'b0100;
    run_txn(10, 8'd42, -1);
    req = '0;

    // Randomized traffic: requesters hold req until served.
    pending = '0;
    for (int it = 0; it < 20; it++) begin
      pending |= 4'($urandom_range(0, 15));
      if (pending == '0) pending = 4'(1 << $urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        t_in[i]  = 8'($urandom_range(0, 255));
        dt_in[i] = 8'($urandom_range(0, 255));
      end
      req_reg_mode = 4'($urandom_range(0, 15));
      req_dt_mode  = 4'($urandom_range(0, 15));
      req = pending;
      run_txn($urandom_range(1, 36), 8'($urandom_range(0, 100)), -1);
      pending &= ~last_gnt;
      req = pending;
    end
    req = '0;
    watch_quiet(3, -1, "idle_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
